// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the RAM command arbiter: command word width,
// command opcodes, arbiter state encoding and the lock timer width.
package ram_arb_pkg;

  localparam int DATA_W  = 18;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    OP_ADDR_ST = 2'b00,
    OP_DATA_WR = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCK     = 3'd1,
    ST_RD_WAIT1 = 3'd2,
    ST_RD_WAIT2 = 3'd3,
    ST_RD_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Rotating-priority picker. Searches the request vector upward starting at
// position ptr (wrapping) and grants the first asserted request.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority position
//   grant out N      one-hot grant, all zero when no request is asserted
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;
  logic [2*N-1:0] gnt_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = req_rot & (~req_rot + N'(1));
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    grant   = gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates NUM_REQ command streams onto a single RAM command port.
// Multi-word transactions (address-store / read-address) lock the port to
// their owner; a read-data command waits out the RAM latency and returns the
// sampled read word to the owner as a one-cycle response.
// Optional feature: define RAM_ARB_TIMEOUT_EN to drop a lock after TIMEOUT
// consecutive idle cycles of the owner (pulses timeout_err).
// Ports:
//   sys_clock     in   clock, rising edge
//   reset         in   synchronous active-high reset
//   req_valid     in   NUM_REQ      command word valid per requester
//   req_data      in   NUM_REQ*18   command words, requester i at [18i+17:18i]
//   req_ready     out  NUM_REQ      word accepted this cycle
//   rsp_valid     out  NUM_REQ      read response pulse to owner
//   rsp_data      out  18           read response word (held between responses)
//   ram_rx_valid  out  1            registered command strobe to RAM
//   ram_data_in   out  18           registered command word to RAM
//   ram_data_out  in   18           RAM read data
//   busy          out  1            state is not IDLE
//   timeout_err   out  1            lock timeout pulse
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      sys_clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ram_rx_valid,
  output logic [DATA_W-1:0]         ram_data_in,
  input  logic [DATA_W-1:0]         ram_data_out,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W-1:0]   arb_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  grant_word_p0;
  opcode_t            grant_op;
  logic               accept;

`ifdef RAM_ARB_TIMEOUT_EN
  logic [TIMER_W-1:0] timer;
  logic               timeout_hit;
`endif

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign owner_oh = NUM_REQ'(1) << owner;

  // RD_RESP ends the current read, so it already arbitrates with the
  // post-transaction pointer; otherwise the finished owner could win again.
  always_comb begin
    arb_req = '0;
    arb_ptr = rr_ptr;
    case (state)
      ST_IDLE:    arb_req = req_valid;
      ST_LOCK:    arb_req = req_valid & owner_oh;
      ST_RD_RESP: begin
        arb_req = req_valid;
        arb_ptr = next_idx(owner);
      end
      default:    arb_req = '0;
    endcase
    if (reset) arb_req = '0;
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx     = '0;
    grant_word_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx     = IDX_W'(i);
        grant_word_p0 = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept    = |grant;
  assign grant_op  = opcode_t'(grant_word_p0[DATA_W-1 -: 2]);
  assign req_ready = grant;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
`ifdef RAM_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_LOCK, ST_RD_RESP: begin
        if (state == ST_RD_RESP) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = next_idx(owner);
        end
        if (accept) begin
          owner_nxt = grant_idx;
          case (grant_op)
            OP_ADDR_ST, OP_RD_ADDR: state_nxt = ST_LOCK;
            OP_DATA_WR: begin
              state_nxt  = ST_IDLE;
              rr_ptr_nxt = next_idx(grant_idx);
            end
            OP_RD_DATA: state_nxt = ST_RD_WAIT1;
            default:    state_nxt = ST_IDLE;
          endcase
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (state == ST_LOCK && timer == TIMER_W'(TIMEOUT - 1)) begin
          state_nxt   = ST_IDLE;
          rr_ptr_nxt  = next_idx(owner);
          timeout_hit = 1'b1;
        end
`endif
      end
      ST_RD_WAIT1: state_nxt = ST_RD_WAIT2;
      ST_RD_WAIT2: state_nxt = ST_RD_RESP;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: accepted word to the RAM, read capture, control state.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      ram_rx_valid <= 1'b0;
      ram_data_in  <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      owner        <= owner_nxt;
      ram_rx_valid <= accept;
      ram_data_in  <= accept ? grant_word_p0 : '0;
      rsp_valid    <= (state == ST_RD_WAIT2) ? owner_oh : '0;
      if (state == ST_RD_WAIT2) rsp_data <= ram_data_out;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (state == ST_LOCK && !accept && !timeout_hit) timer <= timer + 1'b1;
      else                                             timer <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed-vector bench for ram_arbiter (NUM_REQ=2, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_ram_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DW      = 18;

  logic                   sys_clock = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic                   ram_rx_valid;
  logic [DW-1:0]          ram_data_in;
  logic [DW-1:0]          ram_data_out;
  logic                   busy;
  logic                   timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clock = ~sys_clock;

  ram_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (16)
  ) dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_rx_valid (ram_rx_valid),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clock);
    #1;
  endtask

  function automatic logic [17:0] mk(input logic [1:0] op, input logic [15:0] val);
    return {op, val};
  endfunction

  task automatic set_req(input logic [1:0] vld, input logic [17:0] w0, input logic [17:0] w1);
    req_valid = vld;
    req_data  = {w1, w0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   32'(req_ready),    32'h0);
    check({tag, "_rspv"},    32'(rsp_valid),    32'h0);
    check({tag, "_rspd"},    32'(rsp_data),     32'h0);
    check({tag, "_ramv"},    32'(ram_rx_valid), 32'h0);
    check({tag, "_ramd"},    32'(ram_data_in),  32'h0);
    check({tag, "_busy"},    32'(busy),         32'h0);
    check({tag, "_tmo"},     32'(timeout_err),  32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    ram_data_out = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Lock by req0 (00 then 01) while req1 waits.
    set_req(2'b11, mk(2'b00, 16'h0005), mk(2'b01, 16'h1111));
    #1 check("lock_grant0", 32'(req_ready), 32'h1);
    tick();
    check("lock_ramv0", 32'(ram_rx_valid), 32'h1);
    check("lock_ramd0", 32'(ram_data_in), 32'h00005);
    check("lock_busy", 32'(busy), 32'h1);
    set_req(2'b11, mk(2'b01, 16'hBEEF), mk(2'b01, 16'h1111));
    #1 check("lock_stall1", 32'(req_ready), 32'h1);
    tick();
    check("lock_ramd1", 32'(ram_data_in), 32'h1BEEF);
    check("lock_idle", 32'(busy), 32'h0);
    #1 check("lock_then1", 32'(req_ready), 32'h2);
    tick();
    check("lock_ramd2", 32'(ram_data_in), 32'h11111);
    set_req(2'b00, '0, '0);
    tick();
    check("idle_ramv", 32'(ram_rx_valid), 32'h0);
    check("idle_ramd", 32'(ram_data_in), 32'h0);

    // Read by req1: 10 then 11 at cycle T; response only in T+3.
    set_req(2'b10, '0, mk(2'b10, 16'h0005));
    #1 check("rd_grant_a", 32'(req_ready), 32'h2);
    tick();
    set_req(2'b10, '0, mk(2'b11, 16'h0000));
    #1 check("rd_grant_d", 32'(req_ready), 32'h2);
    tick();
    set_req(2'b00, '0, '0);
    ram_data_out = 18'h3FFFF;
    check("rd_t1_ramd", 32'(ram_data_in), 32'h30000);
    check("rd_t1_rspv", 32'(rsp_valid), 32'h0);
    check("rd_t1_busy", 32'(busy), 32'h1);
    tick();
    ram_data_out = 18'h0BEEF;
    check("rd_t2_rspv", 32'(rsp_valid), 32'h0);
    check("rd_t2_ramv", 32'(ram_rx_valid), 32'h0);
    tick();
    ram_data_out = 18'h12345;
    check("rd_t3_rspv", 32'(rsp_valid), 32'h2);
    check("rd_t3_rspd", 32'(rsp_data), 32'h0BEEF);
    check("rd_t3_busy", 32'(busy), 32'h1);
    tick();
    check("rd_t4_rspv", 32'(rsp_valid), 32'h0);
    check("rd_t4_hold", 32'(rsp_data), 32'h0BEEF);
    check("rd_t4_busy", 32'(busy), 32'h0);

    // Both requesters with single-word writes alternate 0,1,0,1.
    set_req(2'b11, mk(2'b01, 16'hA000), mk(2'b01, 16'hB000));
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr_%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    set_req(2'b00, '0, '0);
    tick();

    // req0 read in flight; req1 accepted only in RD_RESP.
    set_req(2'b11, mk(2'b11, 16'h0000), mk(2'b01, 16'h2222));
    #1 check("fl_grant0", 32'(req_ready), 32'h1);
    tick();
    set_req(2'b10, '0, mk(2'b01, 16'h2222));
    #1 check("fl_w1_ready", 32'(req_ready), 32'h0);
    tick();
    ram_data_out = 18'h00AAA;
    #1 check("fl_w2_ready", 32'(req_ready), 32'h0);
    tick();
    check("fl_resp_rspv", 32'(rsp_valid), 32'h1);
    check("fl_resp_rspd", 32'(rsp_data), 32'h00AAA);
    #1 check("fl_resp_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(2'b00, '0, '0);
    check("fl_ramd", 32'(ram_data_in), 32'h12222);
    check("fl_ramv", 32'(ram_rx_valid), 32'h1);
    check("fl_rspv", 32'(rsp_valid), 32'h0);
    check("fl_busy", 32'(busy), 32'h0);
    tick();

    // Reset in RD_WAIT1 drops the read.
    set_req(2'b01, mk(2'b11, 16'h0000), '0);
    tick();
    set_req(2'b00, '0, '0);
    reset = 1'b1;
    tick();
    check_all_zero("rst_rd");
    reset = 1'b0;
    ram_data_out = 18'h15555;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_norsp_%0d", i), 32'(rsp_valid), 32'h0);
      check($sformatf("rst_nobusy_%0d", i), 32'(busy), 32'h0);
    end

    // Lock by req0 then silence, req1 waiting.
    set_req(2'b01, mk(2'b00, 16'h0007), '0);
    tick();
    set_req(2'b10, '0, mk(2'b01, 16'h3333));
`ifdef RAM_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      #1 check($sformatf("tmo_stall_%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("tmo_quiet_%0d", i), 32'(timeout_err), 32'h0);
      tick();
    end
    check("tmo_pulse", 32'(timeout_err), 32'h1);
    check("tmo_idle", 32'(busy), 32'h0);
    #1 check("tmo_grant1", 32'(req_ready), 32'h2);
    tick();
    check("tmo_pulse_end", 32'(timeout_err), 32'h0);
`else
    for (int i = 1; i <= 20; i++) begin
      #1 check($sformatf("hold_stall_%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("hold_busy_%0d", i), 32'(busy), 32'h1);
      check($sformatf("hold_tmo_%0d", i), 32'(timeout_err), 32'h0);
      tick();
    end
`endif
    set_req(2'b00, '0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 2, number of requesters; TIMEOUT, 16, idle cycles before a held lock is dropped (range 2..255).
REQ-002 sys_clock  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  NUM_REQ  per-requester command word valid.
REQ-005 req_data  in  NUM_REQ*18  flattened command words, requester i at bits [18i+17:18i], opcode in [17:16].
REQ-006 req_ready  out  NUM_REQ  word accepted this cycle (valid&ready).
REQ-007 rsp_valid  out  NUM_REQ  one-cycle read-response pulse to owning requester.
REQ-008 rsp_data  out  18  read response word, shared by all requesters.
REQ-009 ram_rx_valid  out  1  registered command strobe to the RAM.
REQ-010 ram_data_in  out  18  registered command word to the RAM.
REQ-011 ram_data_out  in  18  RAM read data.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse on lock timeout.

Function
REQ-014 Opcodes SHALL be 00 address-store, 01 data-write, 10 read-address, 11 read-data.
REQ-015 States SHALL be IDLE, LOCK, RD_WAIT1, RD_WAIT2, RD_RESP.
REQ-016 IDLE: round-robin grant among asserted req_valid, starting at rr_ptr; req_ready to the winner only, same cycle, combinationally.
REQ-017 An accepted word SHALL appear on ram_data_in with ram_rx_valid=1 for exactly the next cycle; ram_rx_valid=0 and ram_data_in=0 otherwise.
REQ-018 Accepted opcode 00 or 10 SHALL move to LOCK with owner = granted requester.
REQ-019 Accepted opcode 01 SHALL complete a transaction: stay/return to IDLE.
REQ-020 Accepted opcode 11 SHALL move to RD_WAIT1 with owner recorded.
REQ-021 LOCK: only owner may get req_ready; owner's 00/10 stays LOCK, 01 goes IDLE, 11 goes RD_WAIT1; other requesters stall.
REQ-022 Read latency: read-data accepted cycle T; RAM strobed T+1; ram_data_out sampled at end of T+2; rsp_data valid and rsp_valid[owner]=1 in T+3 only (RD_RESP).
REQ-023 ram_data_out SHALL be sampled only in RD_WAIT2, never by level of any RAM valid signal.
REQ-024 No word SHALL be accepted in RD_WAIT1/RD_WAIT2; RD_RESP SHALL arbitrate as IDLE in the same cycle.
REQ-025 rr_ptr SHALL become (owner+1) mod NUM_REQ when a transaction ends (IDLE-completing accept, RD_RESP, or timeout).
REQ-026 rsp_data SHALL hold its last value between responses.

Reset
REQ-027 reset SHALL force IDLE, rr_ptr=0, owner=0, timer=0, all outputs 0 (req_ready, rsp_valid, rsp_data, ram_rx_valid, ram_data_in, busy, timeout_err).
REQ-028 reset during LOCK or any RD state SHALL drop the transaction; no rsp_valid SHALL follow.

Configuration
REQ-029 Macro RAM_ARB_TIMEOUT_EN defined: in LOCK, count consecutive cycles with no owner accept; at TIMEOUT go IDLE, pulse timeout_err, advance rr_ptr; counter clears on every owner accept.
REQ-030 Without RAM_ARB_TIMEOUT_EN: LOCK held indefinitely, timeout_err tied 0, no counter logic.

Structure
REQ-031 Package ram_arb_pkg SHALL hold DATA_W=18, opcode constants, state encoding.
REQ-032 Sub-module rr_arbiter SHALL implement the NUM_REQ-wide rotating priority picker (requests, pointer in; one-hot grant out).

Verification
REQ-033 Req0 sends 00:0x0005 then 01:0xBEEF, req1 held valid -> req1 stalls until 01 accepted, then granted next cycle; RAM sees both words in order.
REQ-034 Req1 sends 10:0x0005 then 11 accepted cycle T -> rsp_valid[1]=1 only in T+3 with rsp_data=0x0BEEF; rsp_valid[0]=0.
REQ-035 Both valid continuously with single-word 01 commands -> grants alternate 0,1,0,1.
REQ-036 With RAM_ARB_TIMEOUT_EN, req0 sends 00 then goes silent -> IDLE and timeout_err pulse after 16 cycles; req1 granted next.
REQ-037 reset asserted in RD_WAIT1 -> all outputs 0 next cycle, no rsp_valid afterwards.
REQ-038 Req0 read in flight, req1 valid -> req1 accepted no earlier than the RD_RESP cycle.
